// File: rtl/level_col_feeder.sv
// Level column feeder: fetches level ROM columns and hands them to the block array one Shift at a time.
// Define FEEDER_WRAP_EN to loop the level forever instead of halting in END after the last column.
module level_col_feeder #(
  parameter int LEVEL_LEN    = 200,
  parameter int PRELOAD_COLS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        shift_req,
  output logic        rom_rd,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [29:0] new_block_id,
  output logic        shift,
  output logic [7:0]  col_count,
  output logic        preload_done,
  output logic        level_end,
  output logic        overrun
);

  typedef enum logic [1:0] {FETCH, CAPTURE, READY, END} state_t;

  state_t      state, next_state;
  logic [29:0] col_buf;
  logic        pending, pending_next;
  logic        consume, drop, last_col;
  logic        unused_rom_bits;

  assign unused_rom_bits = ^rom_data[31:30];
  assign last_col        = (rom_addr == 8'(LEVEL_LEN - 1));

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    next_state   = state;
    pending_next = pending;
    drop         = 1'b0;
    consume      = 1'b0;

    if (state != END && shift_req) begin
      if (!preload_done || pending) drop = 1'b1;
      else if (state != READY)      pending_next = 1'b1;
    end

    unique case (state)
      // rom_rd is still low in the first FETCH cycle after reset: issue the read first.
      FETCH:   next_state = rom_rd ? CAPTURE : FETCH;
      CAPTURE: next_state = READY;
      READY: begin
        consume = !preload_done || pending || shift_req;
        if (consume) begin
          pending_next = 1'b0;
`ifdef FEEDER_WRAP_EN
          next_state = FETCH;
`else
          next_state = last_col ? END : FETCH;
`endif
        end
      end
      END:     next_state = END;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register, including
  // the column buffer, is cleared by the asynchronous reset so a reset discards a fetch in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FETCH;
      rom_rd       <= 1'b0;
      rom_addr     <= '0;
      col_buf      <= '0;
      new_block_id <= '0;
      shift        <= 1'b0;
      col_count    <= '0;
      preload_done <= 1'b0;
      level_end    <= 1'b0;
      overrun      <= 1'b0;
      pending      <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= pending_next;
      rom_rd  <= (next_state == FETCH);
      shift   <= consume;
      if (drop) overrun <= 1'b1;
      if (state == CAPTURE) col_buf <= rom_data[29:0];
      if (consume) begin
        new_block_id <= col_buf;
        col_count    <= col_count + 8'd1;
        if (col_count == 8'(PRELOAD_COLS - 1)) preload_done <= 1'b1;
        if (next_state == FETCH) rom_addr <= last_col ? 8'd0 : rom_addr + 8'd1;
      end
`ifdef FEEDER_WRAP_EN
      level_end <= consume && last_col;
`else
      if (consume && last_col) level_end <= 1'b1;
`endif
    end
  end

endmodule
